dcache_ctrl: RTL and testbench
==============================

// Module: dcache_ctrl
// PURPOSE
//  Direct-mapped, write-back, write-allocate data-cache controller; the responder driving d_rdy into the hazard unit.
//  Serves pipeline MEM-stage loads/stores; on a miss holds rdy low (freezing all stages) while it writes back and refills.
//  Sits between the MEM stage and the main-memory line port.
// PARAMETERS
//  LINES  8   number of cache lines (power of 2, >=2)
//  AW     16  word-address width
//  DW     16  data word width
//  WPL    4   words per line (fixed; offset = addr[1:0])
// PORTS
//  clk        in   1        clock, all state updates on rising edge
//  rst        in   1        asynchronous, active-high reset
//  re         in   1        load request (MEM stage)
//  we         in   1        store request (MEM stage)
//  addr       in   AW       word address; held stable by pipeline while rdy=0
//  wdata      in   DW       store data
//  rdata      out  DW       load data; valid when rdy=1 and re=1
//  rdy        out  1        request complete this cycle (=d_rdy); 1 when idle
//  mem_re     out  1        line read request to memory
//  mem_we     out  1        line write-back request to memory
//  mem_addr   out  AW-2     line address
//  mem_wdata  out  DW*WPL   victim line data
//  mem_rdata  in   DW*WPL   refill line data, valid with mem_ack
//  mem_ack    in   1        one-cycle pulse: current mem_re/mem_we request done
// BEHAVIOUR
//  - Address split: offset=addr[1:0], index=addr[2+IW-1:2] (IW=log2 LINES), tag=addr[AW-1:2+IW].
//  - Reset (async): state=IDLE; all valid, dirty bits=0; mem_re=mem_we=0; rdy=1 (combinational from IDLE, no req).
//    Data/tag arrays not reset. Reset mid-writeback/refill abandons the transfer; mem_re/mem_we drop immediately.
//  - hit = valid[index] && tag_arr[index]==tag. req = re|we.
//  - rdy (combinational, IDLE only): !req || hit. rdy=0 in all other states. Zero-latency on hit.
//  - rdata = selected word of line[index] (combinational); don't-care when !hit.
//  - Write hit (we && hit in IDLE): word written at clock edge, dirty[index]<=1.
//  - re && we together: treated as a write (store wins); rdata still driven.
//  - FSM:
//    IDLE:  req && !hit && dirty[index] -> WB; req && !hit && !dirty -> ALLOC; else IDLE.
//    WB:    mem_we=1, mem_addr={victim tag,index}, mem_wdata=line[index]; hold until mem_ack -> ALLOC, dirty<=0.
//    ALLOC: mem_re=1, mem_addr={tag,index}; on mem_ack: line<=mem_rdata, tag<=tag, valid<=1, dirty<=0 -> IDLE.
//    IDLE re-evaluates next cycle: now a hit, so rdy=1 and a store is merged then (earliest rdy 1 cycle after ack).
//  - mem_re, mem_we registered from next-state; never both 1; mem_addr/mem_wdata stable while request high.
//  - mem_ack outside WB/ALLOC is ignored. mem_ack may arrive any cycle >=1 after request asserts.
//  - Pipeline contract: while rdy=0, re/we/addr/wdata unchanged; controller does not latch the request.
// STRUCTURE
//  - Shared package: state encoding (IDLE=2'd0, WB=2'd1, ALLOC=2'd2), WPL, offset width, line-width macro.
//  - One sub-module: dcache_array (tag/valid/dirty/data storage; async-read, sync word-write and line-fill ports,
//    async clear of valid/dirty). dcache_ctrl holds FSM, hit compare, word mux, memory handshake.
// TESTING
//  1. Reset, re=1 addr=0x0010 -> rdy=0, next cycle mem_re=1 mem_addr=0x0004; ack with 0x4444_3333_2222_1111 -> 1 cycle later rdy=1 rdata=0x1111.
//  2. Then we=1 addr=0x0011 wdata=0xBEEF -> rdy=1 same cycle; re addr=0x0011 -> rdata=0xBEEF; dirty[4]=1.
//  3. re addr=0x0030 (same index 4) -> mem_we, mem_addr=0x0004, mem_wdata=0x4444_3333_BEEF_1111; ack -> mem_re mem_addr=0x000C.
//  4. re=we=0 for 10 cycles -> rdy=1 throughout, mem_re=mem_we=0.
//  5. Miss with mem_ack delayed 6 cycles -> rdy=0 and mem_addr constant all 6 cycles; single refill only.
//  6. Assert rst during WB -> mem_we=0 immediately, rdy=1; prior hit address 0x0010 now misses (valid cleared).
//  7. re=we=1 addr=0x0012 on hit -> word written, dirty set, rdy=1.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache controller.
// State encoding, line geometry and the line-width helper macro.
`ifndef DCACHE_PKG_SV
`define DCACHE_PKG_SV

`define DCACHE_LINE_W(dw) ((dw) * dcache_pkg::WPL)

package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WB    = 2'd1,
        ALLOC = 2'd2
    } state_t;

    localparam int WPL   = 4;
    localparam int OFF_W = 2;

endpackage

`endif

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage for the data cache: async read of one line,
// sync word-write and line-fill ports, async clear of valid/dirty.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int LINES = 8,
    parameter int IW    = 3,
    parameter int TW    = 11,
    parameter int DW    = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [IW-1:0]                  rd_index,
    output logic                           rd_valid,
    output logic                           rd_dirty,
    output logic [TW-1:0]                  rd_tag,
    output logic [`DCACHE_LINE_W(DW)-1:0]  rd_line,
    input  logic                           wr_en,
    input  logic [IW-1:0]                  wr_index,
    input  logic [OFF_W-1:0]               wr_off,
    input  logic [DW-1:0]                  wr_data,
    input  logic                           fill_en,
    input  logic [IW-1:0]                  fill_index,
    input  logic [TW-1:0]                  fill_tag,
    input  logic [`DCACHE_LINE_W(DW)-1:0]  fill_line,
    input  logic                           clean_en,
    input  logic [IW-1:0]                  clean_index
);

    localparam int LW = `DCACHE_LINE_W(DW);

    logic [LINES-1:0] valid_q, valid_d;
    logic [LINES-1:0] dirty_q, dirty_d;
    logic [LW-1:0]    data_mem [LINES];
    logic [TW-1:0]    tag_mem  [LINES];

    // A fill always leaves the line clean, overriding any same-cycle dirty update.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (wr_en)
            dirty_d[wr_index] = 1'b1;
        if (clean_en)
            dirty_d[clean_index] = 1'b0;
        if (fill_en) begin
            valid_d[fill_index] = 1'b1;
            dirty_d[fill_index] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_mem[fill_index] <= fill_line;
            tag_mem[fill_index]  <= fill_tag;
        end else if (wr_en) begin
            for (int w = 0; w < WPL; w++)
                if (wr_off == w[OFF_W-1:0])
                    data_mem[wr_index][w*DW +: DW] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_dirty = dirty_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_line  = data_mem[rd_index];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Answers MEM-stage loads/stores with zero latency on a hit; otherwise writes back and refills.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES = 8,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           re,
    input  logic                           we,
    input  logic [AW-1:0]                  addr,
    input  logic [DW-1:0]                  wdata,
    output logic [DW-1:0]                  rdata,
    output logic                           rdy,
    output logic                           mem_re,
    output logic                           mem_we,
    output logic [AW-3:0]                  mem_addr,
    output logic [`DCACHE_LINE_W(DW)-1:0]  mem_wdata,
    input  logic [`DCACHE_LINE_W(DW)-1:0]  mem_rdata,
    input  logic                           mem_ack
);

    localparam int IW = $clog2(LINES);
    localparam int TW = AW - OFF_W - IW;
    localparam int LW = `DCACHE_LINE_W(DW);

    state_t state_q, state_d;
    logic   mem_re_q, mem_re_d;
    logic   mem_we_q, mem_we_d;

    logic [OFF_W-1:0] off;
    logic [IW-1:0]    index;
    logic [TW-1:0]    tag;
    logic             req, hit;
    logic             rd_valid, rd_dirty;
    logic [TW-1:0]    rd_tag;
    logic [LW-1:0]    rd_line;
    logic             wr_en, fill_en, clean_en;

    assign off   = addr[OFF_W-1:0];
    assign index = addr[OFF_W+IW-1:OFF_W];
    assign tag   = addr[AW-1:OFF_W+IW];
    assign req   = re | we;
    assign hit   = rd_valid && (rd_tag == tag);

    dcache_array #(
        .LINES (LINES),
        .IW    (IW),
        .TW    (TW),
        .DW    (DW)
    ) u_array (
        .clk         (clk),
        .rst         (rst),
        .rd_index    (index),
        .rd_valid    (rd_valid),
        .rd_dirty    (rd_dirty),
        .rd_tag      (rd_tag),
        .rd_line     (rd_line),
        .wr_en       (wr_en),
        .wr_index    (index),
        .wr_off      (off),
        .wr_data     (wdata),
        .fill_en     (fill_en),
        .fill_index  (index),
        .fill_tag    (tag),
        .fill_line   (mem_rdata),
        .clean_en    (clean_en),
        .clean_index (index)
    );

    // The request is never latched: the pipeline holds addr steady while rdy is low,
    // so index/tag stay valid through write-back and refill.
    always_comb begin
        state_d  = state_q;
        wr_en    = 1'b0;
        fill_en  = 1'b0;
        clean_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && !hit)
                    state_d = rd_dirty ? WB : ALLOC;
                else if (we && hit)
                    wr_en = 1'b1;
            end
            WB: begin
                if (mem_ack) begin
                    clean_en = 1'b1;
                    state_d  = ALLOC;
                end
            end
            ALLOC: begin
                if (mem_ack) begin
                    fill_en = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        mem_re_d = (state_d == ALLOC);
        mem_we_d = (state_d == WB);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mem_re_q <= 1'b0;
            mem_we_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mem_re_q <= mem_re_d;
            mem_we_q <= mem_we_d;
        end
    end

    always_comb begin
        rdata = '0;
        for (int w = 0; w < WPL; w++)
            if (off == w[OFF_W-1:0])
                rdata = rd_line[w*DW +: DW];
    end

    assign rdy       = (state_q == IDLE) && (!req || hit);
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = (state_q == WB) ? {rd_tag, index} : addr[AW-1:OFF_W];
    assign mem_wdata = rd_line;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl: hits, misses, write-back,
// delayed acknowledge, reset mid-transfer and combined load/store.
module tb_dcache_ctrl;

    logic        clk;
    logic        rst;
    logic        re;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        rdy;
    logic        mem_re;
    logic        mem_we;
    logic [13:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int passes = 0;

    dcache_ctrl #(.LINES(8), .AW(16), .DW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .re        (re),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .rdy       (rdy),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; re = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        tick();
        tick();
        check_output("reset_rdy", 64'(rdy), 64'd1);
        check_output("reset_mem_re", 64'(mem_re), 64'd0);
        check_output("reset_mem_we", 64'(mem_we), 64'd0);
        rst = 1'b0;
        tick();

        // cold miss on 0x0010 -> refill line 4
        re = 1'b1; addr = 16'h0010;
        #1;
        check_output("t1_miss_rdy", 64'(rdy), 64'd0);
        tick();
        check_output("t1_mem_re", 64'(mem_re), 64'd1);
        check_output("t1_mem_we", 64'(mem_we), 64'd0);
        check_output("t1_mem_addr", 64'(mem_addr), 64'h0004);
        mem_ack = 1'b1; mem_rdata = 64'h4444_3333_2222_1111;
        tick();
        mem_ack = 1'b0;
        check_output("t1_hit_rdy", 64'(rdy), 64'd1);
        check_output("t1_rdata", 64'(rdata), 64'h1111);
        check_output("t1_mem_re_drop", 64'(mem_re), 64'd0);

        // store hit then load back
        re = 1'b0; we = 1'b1; addr = 16'h0011; wdata = 16'hBEEF;
        #1;
        check_output("t2_store_rdy", 64'(rdy), 64'd1);
        tick();
        we = 1'b0; re = 1'b1;
        #1;
        check_output("t2_load_rdata", 64'(rdata), 64'hBEEF);
        check_output("t2_load_rdy", 64'(rdy), 64'd1);

        // conflict miss on dirty line 4 -> write-back then refill
        addr = 16'h0030;
        #1;
        check_output("t3_miss_rdy", 64'(rdy), 64'd0);
        tick();
        check_output("t3_mem_we", 64'(mem_we), 64'd1);
        check_output("t3_mem_re", 64'(mem_re), 64'd0);
        check_output("t3_wb_addr", 64'(mem_addr), 64'h0004);
        check_output("t3_wb_data", mem_wdata, 64'h4444_3333_BEEF_1111);
        check_output("t3_wb_rdy", 64'(rdy), 64'd0);
        mem_ack = 1'b1; mem_rdata = 64'hDDDD_CCCC_BBBB_AAAA;
        tick();
        mem_ack = 1'b0;
        check_output("t3_alloc_re", 64'(mem_re), 64'd1);
        check_output("t3_alloc_we", 64'(mem_we), 64'd0);
        check_output("t3_alloc_addr", 64'(mem_addr), 64'h000C);
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_output("t3_hit_rdy", 64'(rdy), 64'd1);
        check_output("t3_rdata", 64'(rdata), 64'hAAAA);

        // idle cycles; a stray ack must be ignored
        re = 1'b0; we = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mem_ack = (i == 3);
            #1;
            check_output($sformatf("t4_idle_%0d", i), {61'd0, rdy, mem_re, mem_we}, 64'b100);
            tick();
        end
        mem_ack = 1'b0;

        // miss on clean invalid line 1 with ack delayed six cycles
        re = 1'b1; addr = 16'h0044;
        #1;
        check_output("t5_miss_rdy", 64'(rdy), 64'd0);
        tick();
        for (int i = 0; i < 6; i++) begin
            check_output($sformatf("t5_wait_%0d", i), {49'd0, rdy, mem_re, mem_we, mem_addr}, {49'd0, 3'b010, 14'h0011});
            tick();
        end
        mem_ack = 1'b1; mem_rdata = 64'h8888_7777_6666_5555;
        tick();
        mem_ack = 1'b0;
        check_output("t5_rdata", 64'(rdata), 64'h5555);
        for (int i = 0; i < 3; i++) begin
            check_output($sformatf("t5_after_%0d", i), {62'd0, rdy, mem_re}, 64'b10);
            tick();
        end

        // load+store together on a hit: store wins, old word still driven
        re = 1'b1; we = 1'b1; addr = 16'h0046; wdata = 16'hCAFE;
        #1;
        check_output("t7_rdy", 64'(rdy), 64'd1);
        check_output("t7_rdata_old", 64'(rdata), 64'h7777);
        tick();
        we = 1'b0;
        #1;
        check_output("t7_rdata_new", 64'(rdata), 64'hCAFE);

        // evicting line 1 proves it was marked dirty
        addr = 16'h0064;
        #1;
        check_output("t7_evict_rdy", 64'(rdy), 64'd0);
        tick();
        check_output("t7_evict_we", 64'(mem_we), 64'd1);
        check_output("t7_evict_addr", 64'(mem_addr), 64'h0011);
        check_output("t7_evict_data", mem_wdata, 64'h8888_CAFE_6666_5555);

        // reset during write-back abandons it and invalidates everything
        rst = 1'b1; re = 1'b0;
        #1;
        check_output("t6_rst_mem_we", 64'(mem_we), 64'd0);
        check_output("t6_rst_mem_re", 64'(mem_re), 64'd0);
        check_output("t6_rst_rdy", 64'(rdy), 64'd1);
        tick();
        rst = 1'b0;
        re = 1'b1; addr = 16'h0030;
        #1;
        check_output("t6_prior_hit_miss", 64'(rdy), 64'd0);
        tick();
        check_output("t6_refetch_re", 64'(mem_re), 64'd1);
        check_output("t6_refetch_addr", 64'(mem_addr), 64'h000C);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
